// File: rtl/parity_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parity_frame_sequencer
// Description : Frame controller for the serial parity path. Accepts a
//               parallel word over valid/ready, shifts it out LSB-first one
//               bit per accepted beat, appends one parity bit, then holds off
//               new words for a programmable idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_sequencer #(
    parameter int NUM_BITS        = 4,
    parameter bit EVEN_PARITY_BIT = 1'b1,
    parameter int GAP_CYCLES      = 2,
    parameter int FRAME_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BITS-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   ser_data,
    output logic                   ser_valid,
    input  logic                   ser_ready,
    output logic                   ser_first,
    output logic                   ser_last,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    // Index counts 0..NUM_BITS-1 but is sized to hold NUM_BITS as well.
    localparam int IDX_W = $clog2(NUM_BITS + 1);
    // A zero-cycle gap still needs a legal (unused) 1-bit counter.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_BITS - 1);
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_BITS-1:0]    r_shreg;
    logic                   r_acc;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic w_in_ready;
    logic w_ser_data;
    logic w_ser_valid;
    logic w_ser_first;
    logic w_ser_last;
    logic w_busy;

    // Frame sequencer: load, shift with backpressure, parity beat, idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_acc       <= 1'b0;
            r_bit_idx   <= '0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg   <= in_data;
                        r_acc     <= EVEN_PARITY_BIT;
                        r_bit_idx <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        r_acc     <= r_acc ^ r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == C_LAST_IDX) begin
                            r_state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (ser_ready) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= C_GAP_LOAD;
                            r_state   <= S_GAP;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    // Counter is preloaded with GAP_CYCLES-1 so the state
                    // lasts exactly GAP_CYCLES cycles.
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only; in_ready is also gated by
    // rst so no word is offered while the block is held in reset.
    always_comb begin
        w_in_ready  = 1'b0;
        w_ser_data  = 1'b0;
        w_ser_valid = 1'b0;
        w_ser_first = 1'b0;
        w_ser_last  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~rst;
            end
            S_SHIFT: begin
                w_ser_valid = 1'b1;
                w_ser_data  = r_shreg[0];
                w_ser_first = (r_bit_idx == '0);
                w_busy      = 1'b1;
            end
            S_PARITY: begin
                w_ser_valid = 1'b1;
                w_ser_data  = r_acc;
                w_ser_last  = 1'b1;
                w_busy      = 1'b1;
            end
            S_GAP: begin
                w_busy = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign ser_data  = w_ser_data;
    assign ser_valid = w_ser_valid;
    assign ser_first = w_ser_first;
    assign ser_last  = w_ser_last;
    assign busy      = w_busy;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
